// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncdeb_pkg.sv
// Shared types and constants for the synchronising debouncer and its chain.
package gf180mcu_fd_sc_mcu9t5v0__syncdeb_pkg;

  // Debounce FSM: STABLE tracks the committed level, CHECK counts confirmations.
  typedef enum logic [0:0] {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } deb_state_e;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  // Fewer than two flops gives no metastability protection; more than four
  // only adds latency.
  function automatic bit sync_depth_ok(input int depth);
    return (depth >= SYNC_MIN) && (depth <= SYNC_MAX);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncdeb_if.sv
// Bundle of the debouncer's data/control inputs and its conditioned outputs.
interface gf180mcu_fd_sc_mcu9t5v0__syncdeb_if #(
  parameter int CNT_W = 4
);
  logic             D;
  logic             EN;
  logic [CNT_W-1:0] THRESH;
  logic             Q;
  logic             RISE;
  logic             FALL;
  logic             BUSY;

  // Driver of the raw level and configuration; consumer of the clean level.
  modport master (output D, output EN, output THRESH,
                  input  Q, input  RISE, input  FALL, input BUSY);

  // The debouncer itself.
  modport slave  (input  D, input  EN, input  THRESH,
                  output Q, output RISE, output FALL, output BUSY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_chain.sv
// Plain flop-chain synchroniser for one asynchronous bit.
module gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);
  logic [DEPTH-1:0] chain_r;

  // Shift the raw level one stage per edge; stage 0 is the first to see D.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[DEPTH-2:0], D};
    end
  end

  assign Q = chain_r[DEPTH-1];
endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__syncdeb.sv
// Synchronise an asynchronous level, then commit a change only after
// THRESH+1 consecutive mismatching samples; emit registered edge pulses.
module gf180mcu_fd_sc_mcu9t5v0__syncdeb
  import gf180mcu_fd_sc_mcu9t5v0__syncdeb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  gf180mcu_fd_sc_mcu9t5v0__syncdeb_if.slave   bus
);
  if (!sync_depth_ok(SYNC_STAGES)) begin : g_bad_depth
    $error("SYNC_STAGES out of range 2..4");
  end

  logic             sample_s;
  deb_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_r;
  logic             rise_r;
  logic             fall_r;

  gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (bus.D),
    .Q   (sample_s)
  );

  // Debounce FSM, confirmation counter and edge-pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= STABLE;
      cnt_r   <= '0;
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else if (!bus.EN) begin
      // Frozen: hold state, count and level; suppress pulses.
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        STABLE: begin
          if (sample_s != q_r) begin
            if (bus.THRESH == '0) begin
              q_r    <= sample_s;
              rise_r <= sample_s;
              fall_r <= ~sample_s;
            end else begin
              state_r <= CHECK;
              cnt_r   <= CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (sample_s == q_r) begin
            // Glitch: level went back before enough confirmations.
            state_r <= STABLE;
            cnt_r   <= '0;
          end else if (cnt_r >= bus.THRESH) begin
            // >= so that lowering THRESH mid-check commits at once.
            q_r     <= sample_s;
            rise_r  <= sample_s;
            fall_r  <= ~sample_s;
            state_r <= STABLE;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= STABLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.Q    = q_r;
  assign bus.RISE = rise_r;
  assign bus.FALL = fall_r;
  assign bus.BUSY = (state_r == CHECK);
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__syncdeb.sv
// Directed + randomized bench for the synchronising debouncer.
module tb_gf180mcu_fd_sc_mcu9t5v0__syncdeb;
  localparam int SYNC = 2;
  localparam int CW   = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  gf180mcu_fd_sc_mcu9t5v0__syncdeb_if #(.CNT_W(CW)) bus ();

  gf180mcu_fd_sc_mcu9t5v0__syncdeb #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Reference model: the synchroniser is a plain delay line of past D
  // samples; the filter remembers how many mismatching samples in a row it
  // has seen (0 = settled), committing once that run exceeds THRESH.
  logic m_pipe [SYNC];
  int   m_run;
  logic m_q, m_rise, m_fall;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_run = 0; m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
  endtask

  task automatic model_edge();
    logic s;
    if (RST) begin
      model_reset();
      return;
    end
    s = m_pipe[SYNC-1];
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (bus.EN) begin
      if (s == m_q) begin
        m_run = 0;
      end else if (m_run >= int'(bus.THRESH)) begin
        m_q = s; m_rise = s; m_fall = ~s; m_run = 0;
      end else begin
        m_run = m_run + 1;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = bus.D;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Q"},    bus.Q,    m_q);
    check({tag, ".RISE"}, bus.RISE, m_rise);
    check({tag, ".FALL"}, bus.FALL, m_fall);
    check({tag, ".BUSY"}, bus.BUSY, m_run != 0);
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample at +1.
  task automatic step(input logic d, input logic en, input logic [CW-1:0] th,
                      input string tag);
    bus.D = d; bus.EN = en; bus.THRESH = th;
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic d;
    int   hold;
    logic [CW-1:0] th;
    model_reset();
    bus.D = 1'b1; bus.EN = 1'b1; bus.THRESH = 4'd3;

    // Reset held with D=1: everything stays zero, including the sample.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 4'd3, "reset");
      check("reset.s", dut.sample_s, 1'b0);
    end
    RST = 1'b0;
    step(1'b0, 1'b1, 4'd3, "idle");
    step(1'b0, 1'b1, 4'd3, "idle");

    // Clean rise: BUSY after edges 3-5, Q/RISE after edge 6.
    for (int e = 1; e <= 8; e++) begin
      step(1'b1, 1'b1, 4'd3, "rise");
      if (e >= 3 && e <= 5) check("rise.busy_window", bus.BUSY, 1'b1);
      if (e == 6) check("rise.edge6", bus.RISE, 1'b1);
      if (e == 7) check("rise.one_cycle", bus.RISE, 1'b0);
    end
    // Clean fall.
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b1, 4'd3, "fall");
      if (e == 6) check("fall.edge6", bus.FALL, 1'b1);
    end

    // Glitch of 3 samples rejected at THRESH=3.
    for (int e = 1; e <= 3; e++) step(1'b1, 1'b1, 4'd3, "glitch");
    for (int e = 1; e <= 6; e++) step(1'b0, 1'b1, 4'd3, "glitch");
    check("glitch.q_held", bus.Q, 1'b0);

    // Same glitch at THRESH=0 commits at edge 3.
    for (int e = 1; e <= 3; e++) begin
      step(1'b1, 1'b1, 4'd0, "glitch0");
      if (e == 3) check("glitch0.edge3", bus.Q, 1'b1);
    end
    for (int e = 1; e <= 4; e++) step(1'b0, 1'b1, 4'd0, "glitch0");

    // Enable freeze after edge 4 of a rise; commit two edges after re-enable.
    for (int e = 1; e <= 4; e++) step(1'b1, 1'b1, 4'd3, "freeze");
    for (int e = 1; e <= 10; e++) step(1'b1, 1'b0, 4'd3, "freeze.off");
    check("freeze.q_held", bus.Q, 1'b0);
    step(1'b1, 1'b1, 4'd3, "freeze.on");
    step(1'b1, 1'b1, 4'd3, "freeze.on");
    check("freeze.commit", bus.Q, 1'b1);
    step(1'b1, 1'b1, 4'd3, "freeze.on");

    // Threshold lowered to 1 while counter is 2: next mismatch commits.
    for (int e = 1; e <= 4; e++) step(1'b0, 1'b1, 4'd3, "thresh");
    step(1'b0, 1'b1, 4'd1, "thresh.drop");
    check("thresh.commit", bus.FALL, 1'b1);
    step(1'b0, 1'b1, 4'd3, "thresh");

    // Reset mid-operation while Q=1 and in CHECK.
    for (int e = 1; e <= 8; e++) step(1'b1, 1'b1, 4'd3, "mid.rise");
    for (int e = 1; e <= 3; e++) step(1'b0, 1'b1, 4'd3, "mid.check");
    #2 RST = 1'b1;
    #1;
    check("mid.q_async", bus.Q, 1'b0);
    check("mid.busy_async", bus.BUSY, 1'b0);
    model_reset();
    RST = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(1'b1, 1'b1, 4'd3, "mid.after");
      if (e == 6) check("mid.rise6", bus.RISE, 1'b1);
    end

    // Randomized bouncing input with random thresholds and enable drops.
    th = 4'd2;
    for (int n = 0; n < 300; n++) begin
      d = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 7);
      if ($urandom_range(0, 9) == 0) th = 4'($urandom_range(0, 5));
      for (int k = 0; k < hold; k++)
        step(d, $urandom_range(0, 7) != 0, th, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
